// File: rtl/vga_timing_if.sv
// ----------------------------------------------------------------------------
// vga_timing_if
//
// Bundle of the raster timing outputs produced by vga_timing_gen.
//
// Signals:
//   H_Sync       horizontal sync at the configured polarity
//   V_Sync       vertical sync at the configured polarity
//   Blank_n      high only while the beam is inside the active area
//   posx         active-area column (0 outside the active area), W bits
//   posy         active-area row (0 outside the active area), W bits
//   pix_en       one-clk strobe marking each pixel period
//   line_start   one-pixel pulse at the first pixel of every line
//   frame_start  one-pixel pulse at the first pixel of every frame
//
// Modports:
//   master  the timing generator (drives everything)
//   slave   a consumer such as a pixel pipeline or DAC driver
// ----------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int W = 11
);
    logic         H_Sync;
    logic         V_Sync;
    logic         Blank_n;
    logic [W-1:0] posx;
    logic [W-1:0] posy;
    logic         pix_en;
    logic         line_start;
    logic         frame_start;

    modport master (
        output H_Sync, V_Sync, Blank_n, posx, posy, pix_en, line_start, frame_start
    );

    modport slave (
        input H_Sync, V_Sync, Blank_n, posx, posy, pix_en, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for VGA-style displays. A prescaler divides clk
// down to the pixel rate; horizontal and vertical counters walk through
// sync, back porch, active and front porch in that order. All outputs other
// than pix_en are decoded from the counters and registered on the pixel
// strobe, so they trail the counters by exactly one pixel period.
//
// Ports:
//   clk   in   clock, all state updates on its rising edge
//   rst   in   synchronous active-high reset (wins over en)
//   en    in   run enable; when low, every counter and output holds
//   vga   out  vga_timing_if.master bundle (syncs, blank, position, strobes)
//
// Parameters:
//   W                          counter / position width
//   HACTIVE, HFP, HSYN, HBP    horizontal segment lengths in pixels
//   VACTIVE, VFP, VSYN, VBP    vertical segment lengths in lines
//   HPOL, VPOL                 asserted sync level (0 = active-low)
//   CLKDIV                     clk cycles per pixel (>= 1)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int W       = 11,
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYN    = 2,
    parameter int VBP     = 33,
    parameter bit HPOL    = 1'b0,
    parameter bit VPOL    = 1'b0,
    parameter int CLKDIV  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    vga_timing_if.master     vga
);

    localparam int HMAX = HSYN + HBP + HACTIVE + HFP;
    localparam int VMAX = VSYN + VBP + VACTIVE + VFP;

    // A one-bit prescaler is kept even for CLKDIV=1 so the compare below
    // stays well formed; it simply never leaves zero in that case.
    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLKDIV - 1);
    localparam logic [W-1:0]  H_LAST    = W'(HMAX - 1);
    localparam logic [W-1:0]  V_LAST    = W'(VMAX - 1);
    localparam logic [W-1:0]  H_SYN_END = W'(HSYN);
    localparam logic [W-1:0]  V_SYN_END = W'(VSYN);
    localparam logic [W-1:0]  H_ACT_BEG = W'(HSYN + HBP);
    localparam logic [W-1:0]  V_ACT_BEG = W'(VSYN + VBP);
    localparam logic [W-1:0]  H_ACT_END = W'(HSYN + HBP + HACTIVE);
    localparam logic [W-1:0]  V_ACT_END = W'(VSYN + VBP + VACTIVE);

    // Refuse to build a generator whose counters cannot reach the end of a
    // line or frame, or whose pixel clock would never tick.
    if (HMAX > (2**W) - 1) begin : g_hmax_check
        $fatal(1, "vga_timing_gen: HMAX does not fit in W bits");
    end
    if (VMAX > (2**W) - 1) begin : g_vmax_check
        $fatal(1, "vga_timing_gen: VMAX does not fit in W bits");
    end
    if (CLKDIV < 1) begin : g_clkdiv_check
        $fatal(1, "vga_timing_gen: CLKDIV must be at least 1");
    end

    logic [PW-1:0] presc;
    logic [W-1:0]  hcnt;
    logic [W-1:0]  vcnt;
    logic          pix_en_c;

    logic          h_sync_on;
    logic          v_sync_on;
    logic          active_d;
    logic [W-1:0]  posx_d;
    logic [W-1:0]  posy_d;

    logic          h_sync_q;
    logic          v_sync_q;
    logic          blank_n_q;
    logic [W-1:0]  posx_q;
    logic [W-1:0]  posy_q;
    logic          line_start_q;
    logic          frame_start_q;

    // The strobe is the only combinational output; gating it with rst keeps
    // it quiet for the whole reset window, not just after the first edge.
    assign pix_en_c = en && !rst && (presc == PRE_LAST);

    // Pixel prescaler: counts clk cycles inside one pixel period and simply
    // stops (rather than clearing) while en is low, so a paused frame picks
    // up exactly where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (en) begin
            if (presc == PRE_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Raster counters: hcnt steps once per pixel; vcnt steps only on the
    // last pixel of a line, and both wrap together at the end of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en_c) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST) begin
                    vcnt <= '0;
                end else begin
                    vcnt <= vcnt + W'(1);
                end
            end else begin
                hcnt <= hcnt + W'(1);
            end
        end
    end

    // Decode of the current counter position. Blanking comes purely from
    // the active window so it stays correct even for timings where a sync
    // pulse overlaps what looks like an active column.
    always_comb begin
        h_sync_on = (hcnt < H_SYN_END);
        v_sync_on = (vcnt < V_SYN_END);
        active_d  = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END) &&
                    (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);
        posx_d    = '0;
        posy_d    = '0;
        if (active_d) begin
            posx_d = hcnt - H_ACT_BEG;
            posy_d = vcnt - V_ACT_BEG;
        end
    end

    // Output register: captures the decode once per pixel, so downstream
    // logic sees values that are stable for the whole pixel period and lag
    // the counters by one pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync_q      <= ~HPOL;
            v_sync_q      <= ~VPOL;
            blank_n_q     <= 1'b0;
            posx_q        <= '0;
            posy_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en_c) begin
            h_sync_q      <= h_sync_on ? HPOL : ~HPOL;
            v_sync_q      <= v_sync_on ? VPOL : ~VPOL;
            blank_n_q     <= active_d;
            posx_q        <= posx_d;
            posy_q        <= posy_d;
            line_start_q  <= (hcnt == '0);
            frame_start_q <= (hcnt == '0) && (vcnt == '0);
        end
    end

    assign vga.H_Sync      = h_sync_q;
    assign vga.V_Sync      = v_sync_q;
    assign vga.Blank_n     = blank_n_q;
    assign vga.posx        = posx_q;
    assign vga.posy        = posy_q;
    assign vga.pix_en      = pix_en_c;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule
